// File: rtl/calc_if.sv
// Bus bundle between the avalon-side host and calc_controller: start/status,
// SRAM read port and the result handshake.
interface calc_if;
    logic        start_calc;
    logic [15:0] pixel_data;
    logic [15:0] weight_data;
    logic [10:0] pixel_address;
    logic [10:0] weight_address;
    logic        rd_en;
    logic [16:0] result_output;
    logic [3:0]  output_address;
    logic        result_valid;
    logic        busy;
    logic        done_calc;

    modport slave (
        input  start_calc, pixel_data, weight_data,
        output pixel_address, weight_address, rd_en,
        result_output, output_address, result_valid, busy, done_calc
    );

    modport master (
        output start_calc, pixel_data, weight_data,
        input  pixel_address, weight_address, rd_en,
        result_output, output_address, result_valid, busy, done_calc
    );
endinterface

// File: rtl/calc_controller.sv
// Dot-product engine: streams pixel/weight SRAM, accumulates one neuron at a time and
// emits saturated 17-bit results. Define CALC_RELU_EN to clamp negative results to 0.
module calc_controller #(
    parameter int NUM_INPUTS  = 64,
    parameter int NUM_OUTPUTS = 10,
    parameter int ACC_W       = 24
) (
    input logic   clk,
    input logic   n_rst,
    calc_if.slave bus
);
    localparam int IN_W = $clog2(NUM_INPUTS);
    localparam logic [IN_W-1:0]         IN_LAST  = IN_W'(NUM_INPUTS - 1);
    localparam logic [3:0]              OUT_LAST = 4'(NUM_OUTPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(65535);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-65536);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, STORE} state_t;

    state_t                   state_q, state_d;
    logic [IN_W-1:0]          in_idx_q, in_idx_d;
    logic [3:0]               out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rd_en_q, rd_en_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [10:0]              pixel_address_q, pixel_address_d;
    logic [10:0]              weight_address_q, weight_address_d;
    logic [16:0]              result_q, result_d;
    logic [3:0]               out_addr_q, out_addr_d;
    logic                     result_valid_q, result_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic signed [16:0]       px_s, wt_s, prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [16:0]              sat_res;
    logic                     unused_hi;

    // Pixel is unsigned, weight signed; the product always fits in 17 signed bits.
    assign px_s      = {9'd0, bus.pixel_data[7:0]};
    assign wt_s      = {{9{bus.weight_data[7]}}, bus.weight_data[7:0]};
    assign prod      = px_s * wt_s;
    assign prod_ext  = ACC_W'(prod);
    assign unused_hi = ^{bus.pixel_data[15:8], bus.weight_data[15:8]};

    always_comb begin
        if (acc_q > SAT_MAX)      sat_res = 17'h0FFFF;
        else if (acc_q < SAT_MIN) sat_res = 17'h10000;
        else                      sat_res = acc_q[16:0];
`ifdef CALC_RELU_EN
        if (sat_res[16]) sat_res = '0;
`endif
    end

    always_comb begin
        state_d          = state_q;
        in_idx_d         = in_idx_q;
        out_idx_d        = out_idx_q;
        acc_d            = acc_q;
        rd_en_d          = rd_en_q;
        rd_vld_d         = rd_en_q;
        pixel_address_d  = pixel_address_q;
        weight_address_d = weight_address_q;
        result_d         = result_q;
        out_addr_d       = out_addr_q;
        result_valid_d   = 1'b0;
        busy_d           = busy_q;
        done_d           = done_q;

        // SRAM data lands one cycle after rd_en, tracked by rd_vld.
        if (rd_vld_q) acc_d = acc_q + prod_ext;

        case (state_q)
            IDLE: begin
                if (bus.start_calc) begin
                    state_d          = LOAD;
                    in_idx_d         = '0;
                    out_idx_d        = '0;
                    acc_d            = '0;
                    done_d           = 1'b0;
                    busy_d           = 1'b1;
                    rd_en_d          = 1'b1;
                    pixel_address_d  = '0;
                    weight_address_d = '0;
                end
            end
            LOAD: begin
                if (in_idx_q == IN_LAST) begin
                    state_d = DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    in_idx_d         = in_idx_q + 1'b1;
                    pixel_address_d  = pixel_address_q + 11'd1;
                    weight_address_d = weight_address_q + 11'd1;
                end
            end
            DRAIN: state_d = STORE;
            STORE: begin
                result_d       = sat_res;
                out_addr_d     = out_idx_q;
                result_valid_d = 1'b1;
                if (out_idx_q == OUT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // Weight rows are contiguous, so the next row starts one past the last read.
                    state_d          = LOAD;
                    out_idx_d        = out_idx_q + 4'd1;
                    in_idx_d         = '0;
                    acc_d            = '0;
                    rd_en_d          = 1'b1;
                    pixel_address_d  = '0;
                    weight_address_d = weight_address_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q          <= IDLE;
            in_idx_q         <= '0;
            out_idx_q        <= '0;
            acc_q            <= '0;
            rd_en_q          <= 1'b0;
            rd_vld_q         <= 1'b0;
            pixel_address_q  <= '0;
            weight_address_q <= '0;
            result_q         <= '0;
            out_addr_q       <= '0;
            result_valid_q   <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            in_idx_q         <= in_idx_d;
            out_idx_q        <= out_idx_d;
            acc_q            <= acc_d;
            rd_en_q          <= rd_en_d;
            rd_vld_q         <= rd_vld_d;
            pixel_address_q  <= pixel_address_d;
            weight_address_q <= weight_address_d;
            result_q         <= result_d;
            out_addr_q       <= out_addr_d;
            result_valid_q   <= result_valid_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && rd_en_q)
            assert (int'(out_idx_q) * NUM_INPUTS + int'(in_idx_q) < 2048);
    end

    assign bus.rd_en          = rd_en_q;
    assign bus.pixel_address  = pixel_address_q;
    assign bus.weight_address = weight_address_q;
    assign bus.result_output  = result_q;
    assign bus.output_address = out_addr_q;
    assign bus.result_valid   = result_valid_q;
    assign bus.busy           = busy_q;
    assign bus.done_calc      = done_q;
endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: 4-input, 2-neuron build against a 1-cycle SRAM model.
module tb_calc_controller;
    localparam int NI = 4;
    localparam int NO = 2;

    typedef struct {
        int res;
        int addr;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rv_cnt = 0;
    exp_t sb[$];
    int   addr_log[$];
    logic [7:0] pix_mem [NI];
    logic [7:0] wt_mem  [NI*NO];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_if bus();

    calc_controller #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .ACC_W(24)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    // Upper bytes carry junk that the engine must ignore.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.pixel_data  <= {8'hA5, pix_mem[bus.pixel_address[1:0]]};
            bus.weight_data <= {8'h5A, wt_mem[bus.weight_address[2:0]]};
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic int model(input int n);
        int s = 0;
        for (int i = 0; i < NI; i++)
            s += int'(pix_mem[i]) * int'($signed(wt_mem[n*NI + i]));
        if (s > 65535) s = 65535;
        if (s < -65536) s = -65536;
`ifdef CALC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (n_rst && bus.rd_en) addr_log.push_back(int'(bus.weight_address));
        if (n_rst && bus.result_valid) begin
            rv_cnt++;
            if (sb.size() == 0) chk("unexpected_rv", 1, 0);
            else begin
                e = sb.pop_front();
                chk("result", int'($signed(bus.result_output)), e.res);
                chk("out_addr", int'(bus.output_address), e.addr);
                chk("rv_cycle", cyc, e.cyc);
                chk("done_with_rv", int'(bus.done_calc), (e.addr == NO-1) ? 1 : 0);
            end
        end
    end

    task automatic load_basic();
        for (int i = 0; i < NI; i++) begin
            pix_mem[i] = 8'(i + 1);
            wt_mem[i]  = 8'd1;
        end
        wt_mem[4] = 8'd2;
        wt_mem[5] = 8'd0;
        wt_mem[6] = 8'hFF;
        wt_mem[7] = 8'd1;
    endtask

    task automatic load_fill(input logic [7:0] p, input logic [7:0] w);
        for (int i = 0; i < NI; i++) pix_mem[i] = p;
        for (int i = 0; i < NI*NO; i++) wt_mem[i] = w;
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        bus.start_calc = 1'b1;
        for (int n = 0; n < NO; n++) sb.push_back('{model(n), n, cyc + 7 + n*(NI+2)});
        @(posedge clk); #1;
        bus.start_calc = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_idle"}, ok, 1);
        @(negedge clk);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_done"}, int'(bus.done_calc), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, int'({bus.rd_en, bus.result_valid, bus.busy, bus.done_calc}), 0);
        chk({tag, "_res"}, int'({bus.result_output, bus.output_address}), 0);
        chk({tag, "_addr"}, int'({bus.pixel_address, bus.weight_address}), 0);
    endtask

    initial begin
        int found;
        int rv0;
        bus.start_calc = 1'b0;
        load_basic();

        // Reset state and quiet idle
        #2 chk_zero("reset");
        @(negedge clk) n_rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_rd", addr_log.size(), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // Basic run
        start_run();
        chk("busy_running", int'(bus.busy), 1);
        finish_run("basic");

        // Saturation both directions
        load_fill(8'd255, 8'd127);
        start_run();
        finish_run("sat_pos");
        load_fill(8'd255, 8'h80);
        start_run();
        finish_run("sat_neg");

        // Start asserted mid-LOAD must not restart the run
        load_basic();
        addr_log.delete();
        start_run();
        bus.start_calc = 1'b1;
        @(posedge clk); #1;
        bus.start_calc = 1'b0;
        finish_run("no_restart");
        chk("rd_count", addr_log.size(), NI*NO);
        for (int i = 0; i < addr_log.size(); i++) chk("waddr_seq", addr_log[i], i);

        // Sticky done, cleared by the next accepted start
        repeat (10) @(negedge clk);
        chk("done_sticky", int'(bus.done_calc), 1);
        start_run();
        chk("done_cleared", int'(bus.done_calc), 0);
        finish_run("rerun");

        // Reset during neuron1 LOAD
        start_run();
        found = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.rd_en && bus.weight_address >= 11'(NI)) begin
                found = 1;
                break;
            end
        end
        chk("n1_load_seen", found, 1);
        #1 n_rst = 1'b0;
        #1 chk_zero("midrun_rst");
        chk("n1_pending", sb.size(), 1);
        sb.delete();
        rv0 = rv_cnt;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_partial_rv", rv_cnt, rv0);
        chk("done_after_rst", int'(bus.done_calc), 0);
        start_run();
        finish_run("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
